// File: rtl/store_commit_buf_pkg.sv
// Shared sizing defaults for the store commit buffer and its forwarding search.
// Modules take these as parameter defaults so one place sets the buffer geometry.
package store_commit_buf_pkg;

    localparam int STB_ENTRY_NUM = 32;
    localparam int STB_ENTRY_SEL = 5;
    localparam int STB_ADDR_LEN  = 32;
    localparam int STB_DATA_LEN  = 32;

endpackage

// File: rtl/store_commit_buf_fwd_search.sv
// stbuf_fwd_search: youngest-first word-address match over the live window
// [retptr, finptr) of the store buffer; used only when STBUF_FWD_EN is defined.
module stbuf_fwd_search
    import store_commit_buf_pkg::*;
#(
    parameter int ENTRY_NUM = STB_ENTRY_NUM,
    parameter int ENTRY_SEL = STB_ENTRY_SEL,
    parameter int WORD_LEN  = STB_ADDR_LEN - 2,
    parameter int DATA_LEN  = STB_DATA_LEN
) (
    input  logic [ENTRY_SEL:0]                  retptr,
    input  logic [ENTRY_SEL:0]                  finptr,
    input  logic [ENTRY_NUM-1:0][WORD_LEN-1:0]  entry_word,
    input  logic [ENTRY_NUM-1:0][DATA_LEN-1:0]  entry_data,
    input  logic [WORD_LEN-1:0]                 ld_word,
    output logic                                ld_hit,
    output logic [DATA_LEN-1:0]                 ld_data
);

    logic [ENTRY_SEL:0] used;
    logic [ENTRY_SEL:0] ptr;

    assign used = finptr - retptr;

    // Walk from oldest to youngest so the youngest matching store overrides.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        ptr     = '0;
        for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
            ptr = finptr - (ENTRY_SEL+1)'(k + 1);
            if (((ENTRY_SEL+1)'(k) < used) &&
                (entry_word[ptr[ENTRY_SEL-1:0]] == ld_word)) begin
                ld_hit  = 1'b1;
                ld_data = entry_data[ptr[ENTRY_SEL-1:0]];
            end
        end
    end

endmodule

// File: rtl/store_commit_buf.sv
// In-order store buffer: speculative stores wait for stcommit, committed stores
// drain to memory. Store-to-load forwarding is built only when STBUF_FWD_EN is defined.
module store_commit_buf
    import store_commit_buf_pkg::*;
#(
    parameter int ENTRY_NUM = STB_ENTRY_NUM,
    parameter int ENTRY_SEL = STB_ENTRY_SEL,
    parameter int ADDR_LEN  = STB_ADDR_LEN,
    parameter int DATA_LEN  = STB_DATA_LEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prmiss,
    input  logic                 stcommit,
    input  logic                 st_we,
    input  logic [ADDR_LEN-1:0]  st_addr,
    input  logic [DATA_LEN-1:0]  st_data,
    output logic                 full,
    output logic [ENTRY_SEL:0]   used_num,
    output logic                 mem_req,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic [DATA_LEN-1:0]  mem_data,
    input  logic                 mem_ack,
    input  logic [ADDR_LEN-1:0]  ld_addr,
    output logic                 ld_hit,
    output logic [DATA_LEN-1:0]  ld_data
);

    logic [ENTRY_SEL:0] retptr;
    logic [ENTRY_SEL:0] comptr;
    logic [ENTRY_SEL:0] finptr;

    logic [ENTRY_NUM-1:0][ADDR_LEN-1:0] entry_addr;
    logic [ENTRY_NUM-1:0][DATA_LEN-1:0] entry_data;

    logic do_write;
    logic do_commit;
    logic do_retire;

    assign used_num  = finptr - retptr;
    assign full      = (used_num == (ENTRY_SEL+1)'(ENTRY_NUM));
    assign mem_req   = (retptr != comptr);
    assign mem_addr  = entry_addr[retptr[ENTRY_SEL-1:0]];
    assign mem_data  = entry_data[retptr[ENTRY_SEL-1:0]];

    assign do_write  = st_we & ~full & ~prmiss;
    assign do_commit = stcommit & ~prmiss & (comptr != finptr);
    assign do_retire = mem_req & mem_ack;

    // A flush rewinds finptr only; the retire side keeps draining committed stores.
    always_ff @(posedge clk) begin
        if (reset) begin
            retptr <= '0;
            comptr <= '0;
            finptr <= '0;
        end else begin
            if (prmiss) begin
                finptr <= comptr;
            end else begin
                if (do_write)  finptr <= finptr + 1'b1;
                if (do_commit) comptr <= comptr + 1'b1;
            end
            if (do_retire) retptr <= retptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            entry_addr[finptr[ENTRY_SEL-1:0]] <= st_addr;
            entry_data[finptr[ENTRY_SEL-1:0]] <= st_data;
        end
    end

    // Byte offset never takes part in matching (word stores only).
    logic unused_ld_offset;
    assign unused_ld_offset = ^ld_addr[1:0];

`ifdef STBUF_FWD_EN
    logic [ENTRY_NUM-1:0][ADDR_LEN-3:0] entry_word;

    always_comb begin
        entry_word = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            entry_word[i] = entry_addr[i][ADDR_LEN-1:2];
        end
    end

    stbuf_fwd_search #(
        .ENTRY_NUM (ENTRY_NUM),
        .ENTRY_SEL (ENTRY_SEL),
        .WORD_LEN  (ADDR_LEN - 2),
        .DATA_LEN  (DATA_LEN)
    ) u_fwd_search (
        .retptr     (retptr),
        .finptr     (finptr),
        .entry_word (entry_word),
        .entry_data (entry_data),
        .ld_word    (ld_addr[ADDR_LEN-1:2]),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data)
    );
`else
    logic unused_ld_word;
    assign unused_ld_word = ^ld_addr[ADDR_LEN-1:2];
    assign ld_hit  = 1'b0;
    assign ld_data = '0;
`endif

endmodule

// File: tb/tb_store_commit_buf.sv
// Self-checking bench for store_commit_buf: directed table, hand-written corner
// sequences and random traffic against a queue-based model of the buffer.
module tb_store_commit_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        prmiss;
    logic        stcommit;
    logic        st_we;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        full;
    logic [5:0]  used_num;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t com_q[$];
    ent_t spec_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        commit;
        logic        miss;
        logic        ack;
        logic [5:0]  exp_used;
        logic        exp_req;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mdata;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    store_commit_buf dut (
        .clk      (clk),
        .reset    (reset),
        .prmiss   (prmiss),
        .stcommit (stcommit),
        .st_we    (st_we),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .full     (full),
        .used_num (used_num),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ack  (mem_ack),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model state before the coming edge.
    task automatic checkOutput();
        int          m_used;
        logic        m_hit;
        logic [31:0] m_ld;
        ent_t        all_q[$];
        m_used = com_q.size() + spec_q.size();
        chk("used_num", used_num, m_used);
        chk("full", full, m_used == 32);
        chk("mem_req", mem_req, com_q.size() > 0);
        if (com_q.size() > 0) begin
            chk("mem_addr", mem_addr, com_q[0].a);
            chk("mem_data", mem_data, com_q[0].d);
        end
        m_hit = 1'b0;
        m_ld  = '0;
`ifdef STBUF_FWD_EN
        all_q = {com_q, spec_q};
        foreach (all_q[i]) begin
            if (all_q[i].a[31:2] == ld_addr[31:2]) begin
                m_hit = 1'b1;
                m_ld  = all_q[i].d;
            end
        end
`endif
        chk("ld_hit", ld_hit, m_hit);
        chk("ld_data", ld_data, m_ld);
    endtask

    task automatic modelEdge(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic cm, input logic miss, input logic ack);
        bit   full_now;
        ent_t e;
        full_now = (com_q.size() + spec_q.size()) == 32;
        if (ack && com_q.size() > 0) void'(com_q.pop_front());
        if (miss) begin
            spec_q.delete();
        end else begin
            if (cm && spec_q.size() > 0) com_q.push_back(spec_q.pop_front());
            if (we && !full_now) begin
                e.a = a;
                e.d = d;
                spec_q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d,
                                 input logic cm, input logic miss, input logic ack,
                                 input logic [31:0] la);
        st_we    = we;
        st_addr  = a;
        st_data  = d;
        stcommit = cm;
        prmiss   = miss;
        mem_ack  = ack;
        ld_addr  = la;
        #1;
        checkOutput();
        @(posedge clk);
        modelEdge(we, a, d, cm, miss, ack);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic doReset();
        st_we = 0; stcommit = 0; prmiss = 0; mem_ack = 0; ld_addr = '0;
        st_addr = '0; st_data = '0;
        reset = 1'b1;
        @(posedge clk);
        com_q.delete();
        spec_q.delete();
        #1;
        reset = 1'b0;
    endtask

    task automatic drainAll();
        for (int i = 0; i < 70; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
    endtask

    initial begin
        vecs[0] = '{1, 32'h100, 32'hA, 0, 0, 0, 6'd0, 0, 32'h0,   32'h0};
        vecs[1] = '{1, 32'h104, 32'hB, 0, 0, 0, 6'd1, 0, 32'h0,   32'h0};
        vecs[2] = '{1, 32'h108, 32'hC, 0, 0, 0, 6'd2, 0, 32'h0,   32'h0};
        vecs[3] = '{0, 32'h0,   32'h0, 0, 0, 0, 6'd3, 0, 32'h0,   32'h0};
        vecs[4] = '{0, 32'h0,   32'h0, 1, 0, 1, 6'd3, 0, 32'h0,   32'h0};
        vecs[5] = '{0, 32'h0,   32'h0, 1, 0, 1, 6'd3, 1, 32'h100, 32'hA};
        vecs[6] = '{0, 32'h0,   32'h0, 0, 0, 1, 6'd2, 1, 32'h104, 32'hB};
        vecs[7] = '{0, 32'h0,   32'h0, 0, 0, 1, 6'd1, 0, 32'h0,   32'h0};

        reset = 1'b1;
        st_we = 0; stcommit = 0; prmiss = 0; mem_ack = 0;
        st_addr = '0; st_data = '0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_used", used_num, 0);
        chk("reset_full", full, 0);
        chk("reset_req", mem_req, 0);
        chk("reset_ld_hit", ld_hit, 0);

        // Directed table: three stores, two commits, ack held.
        foreach (vecs[i]) begin
            #1;
            chk("tbl_used", used_num, vecs[i].exp_used);
            chk("tbl_req", mem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                chk("tbl_maddr", mem_addr, vecs[i].exp_maddr);
                chk("tbl_mdata", mem_data, vecs[i].exp_mdata);
            end
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data,
                          vecs[i].commit, vecs[i].miss, vecs[i].ack, '0);
        end
        chk("tbl_final_used", used_num, 1);
        drainAll();

        // Flush: 2 committed + 3 speculative, prmiss with write and commit ignored.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h400 + i*4, 32'h50 + i, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'h500, 32'h99, 1'b1, 1'b1, 1'b0, '0);
        chk("flush_used", used_num, 2);
        chk("flush_req", mem_req, 1);
        chk("flush_maddr", mem_addr, 32'h400);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, '0);
        chk("flush_drained", used_num, 0);
        chk("flush_req_low", mem_req, 0);
        idle();

        // Fill to full three times so the pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++)
                applyStimulus(1'b1, 32'h1000 + i*4, r*100 + i, 1'b0, 1'b0, 1'b0, '0);
            chk("fill_full", full, 1);
            chk("fill_used", used_num, 32);
            applyStimulus(1'b1, 32'h2000, 32'hDEAD, 1'b0, 1'b0, 1'b0, '0);
            chk("fill_drop_used", used_num, 32);
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0);
            chk("fill_one_ack_full", full, 0);
            chk("fill_one_ack_used", used_num, 31);
            drainAll();
            chk("fill_empty", used_num, 0);
        end

        // Forwarding lookup: two stores to the same word, youngest wins.
        applyStimulus(1'b1, 32'h200, 32'h1, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'h200, 32'h2, 1'b0, 1'b0, 1'b0, '0);
        ld_addr = 32'h202;
        #1;
`ifdef STBUF_FWD_EN
        chk("fwd_hit", ld_hit, 1);
        chk("fwd_data", ld_data, 32'h2);
`else
        chk("fwd_off_hit", ld_hit, 0);
        chk("fwd_off_data", ld_data, 0);
`endif
        ld_addr = 32'h300;
        #1;
        chk("fwd_miss", ld_hit, 0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 32'h202);
        idle();

        // Reset while committed stores are pending.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h600 + i*4, i, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
        chk("prereset_req", mem_req, 1);
        doReset();
        chk("midreset_req", mem_req, 0);
        chk("midreset_used", used_num, 0);
        chk("midreset_full", full, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 55,
                          32'h200 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3),
                          $urandom,
                          $urandom_range(0, 99) < 40,
                          $urandom_range(0, 99) < 4,
                          $urandom_range(0, 99) < 35,
                          32'h200 + ($urandom_range(0, 17) << 2) + $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
